// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sequencer states, default slice width.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } alu_seq_state_t;

endpackage

// File: rtl/alu_seq_chain_if.sv
// Operand/result handshake bundle for alu_seq_chain.
// zero/ovf exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_seq_chain_if
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int NBYTES = 4
);
    localparam int W = WIDTH * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic [1:0]   control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic         zero;
    logic         ovf;
`endif

    modport master (
        output in_valid, op_a, op_b, cin, control, out_ready,
        input  in_ready, out_valid, result, cout, busy
`ifdef ALU_SEQ_FLAGS_EN
        , input zero, ovf
`endif
    );

    modport slave (
        input  in_valid, op_a, op_b, cin, control, out_ready,
        output in_ready, out_valid, result, cout, busy
`ifdef ALU_SEQ_FLAGS_EN
        , output zero, ovf
`endif
    );

endinterface

// File: rtl/alu_byte_slice.sv
// Combinational WIDTH-bit AND/OR/XOR/ADD-with-carry slice.
module alu_byte_slice
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        y    = '0;
        cout = 1'b0;
        unique case (1'b1)
            (control == ALU_AND): y = a & b;
            (control == ALU_OR):  y = a | b;
            (control == ALU_XOR): y = a ^ b;
            (control == ALU_ADD): begin
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_chain.sv
// Wide-operand sequencer feeding one ALU slice, LSB slice first.
// Optional zero/ovf flags with ALU_SEQ_FLAGS_EN.
module alu_seq_chain
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_chain_if.slave bus
);

    localparam int W  = WIDTH * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    alu_seq_state_t state;
    logic           live_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [1:0]     ctl_q;
    logic           carry_q;
    logic [IW-1:0]  idx;
    logic [W-1:0]   res_q;
    logic           cout_q;
    logic [W-1:0]   res_nxt;

    logic [WIDTH-1:0] s_a;
    logic [WIDTH-1:0] s_b;
    logic [WIDTH-1:0] s_y;
    logic             s_cout;
    logic             accept;

    assign s_a = a_q[idx*WIDTH +: WIDTH];
    assign s_b = b_q[idx*WIDTH +: WIDTH];

    alu_byte_slice #(.WIDTH(WIDTH)) u_slice (
        .a       (s_a),
        .b       (s_b),
        .cin     (carry_q),
        .control (ctl_q),
        .y       (s_y),
        .cout    (s_cout)
    );

    always_comb begin
        res_nxt = res_q;
        res_nxt[idx*WIDTH +: WIDTH] = s_y;
    end

    // live_q keeps in_ready low until the first edge after reset release
    assign bus.in_ready  = live_q && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;
    assign accept        = bus.in_valid && bus.in_ready;

`ifdef ALU_SEQ_FLAGS_EN
    logic zero_q;
    logic ovf_q;
    logic c_msb;

    // carry into the MSB recovered from the top slice's sum bit
    assign c_msb    = s_a[WIDTH-1] ^ s_b[WIDTH-1] ^ s_y[WIDTH-1];
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == IDLE && accept) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == RUN && idx == LAST) begin
            zero_q <= (res_nxt == '0);
            ovf_q  <= (ctl_q == ALU_ADD) && (c_msb ^ s_cout);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            live_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctl_q   <= ALU_AND;
            carry_q <= 1'b0;
            idx     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.op_a;
                        b_q     <= bus.op_b;
                        ctl_q   <= bus.control;
                        carry_q <= bus.cin;
                        idx     <= '0;
                        res_q   <= '0;
                        cout_q  <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_nxt;
                    carry_q <= s_cout;
                    if (idx == LAST) begin
                        cout_q <= s_cout;
                        idx    <= '0;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_chain.sv
// Self-checking bench for alu_seq_chain: directed table, reset cases,
// randomized ops against an arithmetic reference model.
module tb_alu_seq_chain;
    import alu_pkg::*;

    localparam int WIDTH  = 8;
    localparam int NBYTES = 4;
    localparam int W      = WIDTH * NBYTES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_seq_chain_if #(.WIDTH(WIDTH), .NBYTES(NBYTES)) bus ();

    alu_seq_chain #(.WIDTH(WIDTH), .NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [1:0]   ctl;
        logic [W-1:0] res;
        logic         co;
        logic         z;
        logic         v;
        int           hold;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic ci,
                                   input logic [1:0] ctl);
        vec_t v;
        logic [W:0] s;
        v.a = a; v.b = b; v.ci = ci; v.ctl = ctl;
        v.co = 1'b0; v.v = 1'b0; v.hold = 0;
        case (ctl)
            ALU_AND: v.res = a & b;
            ALU_OR:  v.res = a | b;
            ALU_XOR: v.res = a ^ b;
            default: begin
                s     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                v.res = s[W-1:0];
                v.co  = s[W];
                v.v   = (a[W-1] == b[W-1]) && (v.res[W-1] != a[W-1]);
            end
        endcase
        v.z = (v.res == '0);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'(1));
        bus.op_a     = v.a;
        bus.op_b     = v.b;
        bus.cin      = v.ci;
        bus.control  = v.ctl;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.cin      = 1'($urandom_range(1));
        bus.control  = 2'($urandom_range(3));
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(NBYTES));
        check({tag, " result"}, 64'(bus.result), 64'(v.res));
        check({tag, " cout"}, 64'(bus.cout), 64'(v.co));
`ifdef ALU_SEQ_FLAGS_EN
        check({tag, " zero"}, 64'(bus.zero), 64'(v.z));
        check({tag, " ovf"}, 64'(bus.ovf), 64'(v.v));
`endif
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold"},
                  {30'd0, bus.out_valid, bus.in_ready, bus.result},
                  {30'd0, 1'b1, 1'b0, v.res});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " release"},
              64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.cin       = 1'b0;
        bus.control   = ALU_AND;
        bus.out_ready = 1'b0;

        tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, ALU_ADD,
                   32'h00000100, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, ALU_ADD,
                   32'h00000000, 1'b1, 1'b1, 1'b0, 1};
        tbl[2] = '{32'hF0F0A5A5, 32'h0FF0FFFF, 1'b1, ALU_XOR,
                   32'hFF005A5A, 1'b0, 1'b0, 1'b0, 5};
        tbl[3] = '{32'hF0F0A5A5, 32'h0FF0FFFF, 1'b1, ALU_AND,
                   32'h00F0A5A5, 1'b0, 1'b0, 1'b0, 0};
        tbl[4] = '{32'hF0F0A5A5, 32'h0FF0FFFF, 1'b0, ALU_OR,
                   32'hFFF0FFFF, 1'b0, 1'b0, 1'b0, 2};
        tbl[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, ALU_ADD,
                   32'h80000000, 1'b0, 1'b0, 1'b1, 0};

        #12;
        check("reset outputs",
              {29'd0, bus.in_ready, bus.out_valid, bus.busy,
               bus.cout, bus.result},
              64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after release", 64'(bus.in_ready), 64'(1));

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // abort an operation after two slices
        bus.op_a     = 32'h12345678;
        bus.op_b     = 32'h11111111;
        bus.control  = ALU_ADD;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun reset",
              {29'd0, bus.in_ready, bus.out_valid, bus.busy,
               bus.cout, bus.result},
              64'(0));
`ifdef ALU_SEQ_FLAGS_EN
        check("midrun reset flags", 64'({bus.zero, bus.ovf}), 64'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(tbl[5], "post reset");

        for (int i = 0; i < 30; i++) begin
            rv = model($urandom, $urandom, 1'($urandom_range(1)),
                       2'($urandom_range(3)));
            rv.hold = $urandom_range(2);
            run_vec(rv, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
